fifo_pkt_drain: RTL and testbench

Read-side drain controller sitting directly downstream of `synchronous_fifo`. Pops words from the FIFO whenever it holds data and the output has room. Groups every PKT_LEN words into a packet, appends a modulo-2^DATA_W sum checksum beat, and presents the result on a valid/ready stream with a last flag. Sustains one beat per cycle under no backpressure and never pops an empty FIFO.

---
 rtl/fifo_pkt_drain.sv | 151 +++++++++++++++
 tb/tb_fifo_pkt_drain.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_pkt_drain.sv
// Read-side drain for a synchronous FIFO: pops words, groups them into PKT_LEN-beat packets
// and appends a modulo-2^DATA_W sum checksum beat on a valid/ready stream.
module fifo_pkt_drain #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned PKT_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd_en,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  input  logic              m_ready,
  output logic [15:0]       pkt_count
);

  localparam int unsigned     CntW    = $clog2(PKT_LEN + 1);
  localparam logic [CntW-1:0] PktLenC = CntW'(PKT_LEN);

  localparam logic [0:0] StCollect  = 1'b0;
  localparam logic [0:0] StCsumWait = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [CntW-1:0]   issued_q, issued_d;
  logic [CntW-1:0]   pushed_q, pushed_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic              inflight_q;
  logic [1:0]        occ_q, occ_d;
  logic [DATA_W-1:0] buf_data_q [2];
  logic [DATA_W-1:0] buf_data_d [2];
  logic              buf_last_q [2];
  logic              buf_last_d [2];
  logic [15:0]       pkt_count_q, pkt_count_d;

  logic              pop;
  logic [2:0]        credit;
  logic [2:0]        credit_rd;
  logic              csum_push;
  logic [CntW-1:0]   issued_eff;
  logic              push_valid;
  logic [DATA_W-1:0] push_data;
  logic              push_last;

  // Free slots once the current handshake and the word already in flight are accounted for.
  assign pop    = (occ_q != 2'd0) && m_ready;
  assign credit = 3'd2 + {2'b00, pop} - {1'b0, occ_q} - {2'b00, inflight_q};

  assign csum_push = (pushed_q == PktLenC) && (credit != 3'd0);

  // The checksum slot closes the packet this cycle, so the next packet may start reading at once.
  assign issued_eff = csum_push ? '0 : issued_q;
  assign credit_rd  = credit - {2'b00, csum_push};

  assign fifo_rd_en = (state_q == StCollect) && !fifo_empty && (issued_eff < PktLenC) &&
                      (credit_rd != 3'd0);

  // A captured word and the checksum can never coincide: the checksum waits for all pops to land.
  assign push_valid = inflight_q | csum_push;
  assign push_data  = inflight_q ? fifo_data : sum_q;
  assign push_last  = !inflight_q;

  always_comb begin
    state_d  = state_q;
    issued_d = issued_eff + CntW'(fifo_rd_en);
    pushed_d = pushed_q;
    sum_d    = sum_q;

    if (inflight_q) begin
      sum_d    = sum_q + fifo_data;
      pushed_d = pushed_q + CntW'(1);
    end

    if (csum_push) begin
      sum_d    = '0;
      pushed_d = '0;
      state_d  = StCollect;
    end else if (pushed_q == PktLenC) begin
      state_d  = StCsumWait;
    end
  end

  // Two-entry ordered buffer; entry 0 is the head driving the stream.
  always_comb begin
    buf_data_d = buf_data_q;
    buf_last_d = buf_last_q;
    occ_d      = occ_q;

    if (pop && push_valid) begin
      if (occ_q == 2'd1) begin
        buf_data_d[0] = push_data;
        buf_last_d[0] = push_last;
      end else begin
        buf_data_d[0] = buf_data_q[1];
        buf_last_d[0] = buf_last_q[1];
        buf_data_d[1] = push_data;
        buf_last_d[1] = push_last;
      end
    end else if (pop) begin
      buf_data_d[0] = buf_data_q[1];
      buf_last_d[0] = buf_last_q[1];
      occ_d         = occ_q - 2'd1;
    end else if (push_valid) begin
      if (occ_q == 2'd0) begin
        buf_data_d[0] = push_data;
        buf_last_d[0] = push_last;
      end else begin
        buf_data_d[1] = push_data;
        buf_last_d[1] = push_last;
      end
      occ_d = occ_q + 2'd1;
    end
  end

  assign pkt_count_d = pkt_count_q + {15'd0, pop && buf_last_q[0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StCollect;
      issued_q      <= '0;
      pushed_q      <= '0;
      sum_q         <= '0;
      inflight_q    <= 1'b0;
      occ_q         <= 2'd0;
      buf_data_q[0] <= '0;
      buf_data_q[1] <= '0;
      buf_last_q[0] <= 1'b0;
      buf_last_q[1] <= 1'b0;
      pkt_count_q   <= 16'd0;
    end else begin
      state_q       <= state_d;
      issued_q      <= issued_d;
      pushed_q      <= pushed_d;
      sum_q         <= sum_d;
      inflight_q    <= fifo_rd_en;
      occ_q         <= occ_d;
      buf_data_q[0] <= buf_data_d[0];
      buf_data_q[1] <= buf_data_d[1];
      buf_last_q[0] <= buf_last_d[0];
      buf_last_q[1] <= buf_last_d[1];
      pkt_count_q   <= pkt_count_d;
    end
  end

  assign m_valid   = (occ_q != 2'd0);
  assign m_data    = buf_data_q[0];
  assign m_last    = buf_last_q[0];
  assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_fifo_pkt_drain.sv
// Directed bench for fifo_pkt_drain: packet vector table plus backpressure, starvation,
// mid-packet reset and packet-count wrap sequences.
module tb_fifo_pkt_drain;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fifo_empty;
  logic [7:0]  fifo_data = 8'h00;
  logic        fifo_rd_en;
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_last;
  logic        m_ready = 1'b0;
  logic [15:0] pkt_count;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem [0:63];
  int         wr_ptr  = 0;
  int         rd_ptr  = 0;
  int         rd_cnt  = 0;
  int         out_n   = 0;
  int         bad_pop = 0;
  logic [7:0] out_data [0:63];
  logic       out_last [0:63];

  typedef struct {
    logic [7:0] w0, w1, w2, w3, cs;
  } vec_t;
  vec_t vecs [5];

  logic [7:0] bp_exp [10];

  fifo_pkt_drain #(
    .DATA_W  (8),
    .PKT_LEN (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_last     (m_last),
    .m_ready    (m_ready),
    .pkt_count  (pkt_count)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (wr_ptr == rd_ptr);

  // FIFO model with one-cycle read latency, plus pop and output-beat recorders.
  always @(posedge clk) begin
    if (fifo_rd_en && fifo_empty) bad_pop <= bad_pop + 1;
    if (fifo_rd_en && !fifo_empty) begin
      fifo_data <= mem[rd_ptr % 64];
      rd_ptr    <= rd_ptr + 1;
    end
    if (rst) begin
      rd_cnt <= 0;
      out_n  <= 0;
    end else begin
      if (fifo_rd_en) rd_cnt <= rd_cnt + 1;
      if (m_valid && m_ready) begin
        out_data[out_n] <= m_data;
        out_last[out_n] <= m_last;
        out_n           <= out_n + 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [7:0] w);
    mem[wr_ptr % 64] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    m_ready = 1'b0;
    wr_ptr  = rd_ptr;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_out(input int n, input int budget, input string name);
    int k = 0;
    while (out_n < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(out_n >= n), 32'd1);
  endtask

  initial begin
    int stable_bad;

    vecs[0] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
    vecs[1] = '{8'hFF, 8'hFF, 8'h01, 8'h02, 8'h01};
    vecs[2] = '{8'h80, 8'h80, 8'h00, 8'h00, 8'h00};
    vecs[3] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'hA0};
    vecs[4] = '{8'hAA, 8'h55, 8'h01, 8'h00, 8'h00};

    // Reset state
    @(negedge clk);
    do_reset();
    check("reset rd_en", 32'(fifo_rd_en), 32'd0);
    check("reset m_valid", 32'(m_valid), 32'd0);
    check("reset m_data", 32'(m_data), 32'd0);
    check("reset m_last", 32'(m_last), 32'd0);
    check("reset pkt_count", 32'(pkt_count), 32'd0);

    // Latency: pop in the cycle empty falls, valid two cycles later
    m_ready = 1'b1;
    push_word(8'h5A);
    #1;
    check("lat rd_en N", 32'(fifo_rd_en), 32'd1);
    @(negedge clk);
    check("lat m_valid N+1", 32'(m_valid), 32'd0);
    @(negedge clk);
    check("lat m_valid N+2", 32'(m_valid), 32'd1);
    check("lat m_data N+2", 32'(m_data), 32'h5A);

    // Packet table
    for (int i = 0; i < 5; i++) begin
      do_reset();
      m_ready = 1'b1;
      push_word(vecs[i].w0);
      push_word(vecs[i].w1);
      push_word(vecs[i].w2);
      push_word(vecs[i].w3);
      wait_out(5, 40, $sformatf("vec%0d beats", i));
      check($sformatf("vec%0d d0", i), 32'(out_data[0]), 32'(vecs[i].w0));
      check($sformatf("vec%0d d1", i), 32'(out_data[1]), 32'(vecs[i].w1));
      check($sformatf("vec%0d d2", i), 32'(out_data[2]), 32'(vecs[i].w2));
      check($sformatf("vec%0d d3", i), 32'(out_data[3]), 32'(vecs[i].w3));
      check($sformatf("vec%0d last3", i), 32'(out_last[3]), 32'd0);
      check($sformatf("vec%0d csum", i), 32'(out_data[4]), 32'(vecs[i].cs));
      check($sformatf("vec%0d csum last", i), 32'(out_last[4]), 32'd1);
      check($sformatf("vec%0d pkt_count", i), 32'(pkt_count), 32'd1);
      check($sformatf("vec%0d pops", i), 32'(rd_cnt), 32'd4);
    end

    // Backpressure: two packets queued, output stalled 10 cycles
    bp_exp[0] = 8'h10; bp_exp[1] = 8'h20; bp_exp[2] = 8'h30; bp_exp[3] = 8'h40;
    bp_exp[4] = 8'hA0;
    bp_exp[5] = 8'hF0; bp_exp[6] = 8'h0F; bp_exp[7] = 8'h33; bp_exp[8] = 8'h44;
    bp_exp[9] = 8'h76;
    do_reset();
    for (int i = 0; i < 10; i++) if (i != 4 && i != 9) push_word(bp_exp[i]);
    stable_bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m_valid && m_data !== 8'h10) stable_bad++;
    end
    check("bp pops while stalled", 32'(rd_cnt), 32'd2);
    check("bp m_valid held", 32'(m_valid), 32'd1);
    check("bp head stable", 32'(stable_bad), 32'd0);
    check("bp head data", 32'(m_data), 32'h10);
    m_ready = 1'b1;
    wait_out(10, 60, "bp beats");
    for (int i = 0; i < 10; i++) begin
      check($sformatf("bp beat%0d data", i), 32'(out_data[i]), 32'(bp_exp[i]));
      check($sformatf("bp beat%0d last", i), 32'(out_last[i]), 32'(i == 4 || i == 9));
    end
    check("bp pkt_count", 32'(pkt_count), 32'd2);

    // Starvation mid-packet
    do_reset();
    m_ready = 1'b1;
    push_word(8'h11);
    push_word(8'h22);
    repeat (7) @(negedge clk);
    check("starve beats", 32'(out_n), 32'd2);
    check("starve m_valid", 32'(m_valid), 32'd0);
    check("starve pops", 32'(rd_cnt), 32'd2);
    check("starve pkt_count", 32'(pkt_count), 32'd0);
    push_word(8'h33);
    push_word(8'h44);
    wait_out(5, 40, "starve beats after refill");
    check("starve d3", 32'(out_data[3]), 32'h44);
    check("starve last3", 32'(out_last[3]), 32'd0);
    check("starve csum", 32'(out_data[4]), 32'hAA);
    check("starve csum last", 32'(out_last[4]), 32'd1);
    check("starve pkt_count end", 32'(pkt_count), 32'd1);

    // Reset after three accepted beats, with the fourth word buffered
    do_reset();
    m_ready = 1'b1;
    push_word(8'h01);
    push_word(8'h02);
    push_word(8'h03);
    push_word(8'h04);
    wait_out(3, 40, "rst pre beats");
    check("rst pre m_valid", 32'(m_valid), 32'd1);
    check("rst pre m_data", 32'(m_data), 32'h04);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst mid m_valid", 32'(m_valid), 32'd0);
    check("rst mid m_data", 32'(m_data), 32'd0);
    check("rst mid m_last", 32'(m_last), 32'd0);
    check("rst mid rd_en", 32'(fifo_rd_en), 32'd0);
    check("rst mid pkt_count", 32'(pkt_count), 32'd0);
    push_word(8'h21);
    push_word(8'h22);
    push_word(8'h23);
    push_word(8'h24);
    wait_out(5, 40, "rst post beats");
    check("rst post d0", 32'(out_data[0]), 32'h21);
    check("rst post csum", 32'(out_data[4]), 32'h8A);
    check("rst post csum last", 32'(out_last[4]), 32'd1);
    check("rst post pkt_count", 32'(pkt_count), 32'd1);

    // Packet count wrap
    do_reset();
    force dut.pkt_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.pkt_count_q;
    @(negedge clk);
    check("wrap preload", 32'(pkt_count), 32'hFFFF);
    m_ready = 1'b1;
    push_word(8'h01);
    push_word(8'h02);
    push_word(8'h03);
    push_word(8'h04);
    wait_out(5, 40, "wrap beats");
    check("wrap pkt_count", 32'(pkt_count), 32'h0000);

    check("no pop while empty", 32'(bad_pop), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
